dz_count_ctrl: RTL
==================

# dz_count_ctrl

Sequencing controller for the 8x8 dot-matrix countdown display. Generates the row-scan index and active-low row strobe that the dot-matrix renderer consumes. Runs the countdown state machine that supplies the digit value `num` (START_VAL down to 0) at a fixed step period, with start, pause, clear and end-of-count blink. Sits between the board buttons (already debounced and pulsed) and the dot-matrix display block.

## Interface
- `SCAN_DIV`, 1000: clk cycles per row dwell; must be ≥2
- `SEC_DIV`, 50_000_000: clk cycles per countdown step; must be ≥2 and even
- `START_VAL`, 5: initial digit; legal range 1..7, elaborated with an assertion
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: reset; asynchronous, active-low
- `start` in 1: one-cycle pulse; start, resume or restart
- `pause` in 1: one-cycle pulse; toggles RUN/PAUSE
- `clear` in 1: one-cycle pulse; return to IDLE
- `num` out 3: digit to display
- `row_idx` out 3: current scanned row 0..7
- `row` out 8: active-low one-hot row strobe, `row = ~(8'b1 << row_idx)`
- `blank` out 1: 1 = display must suppress columns (blink off phase)
- `done` out 1: 1 while in DONE
- `state` out 2: FSM state, for debug/LEDs

## Operation
- Scan: free-running, independent of the FSM, active whenever `rst` is high.
  - Scan counter runs 0..SCAN_DIV-1.
  - On terminal count, `row_idx` increments mod 8; 7 wraps to 0.
  - `row` updates on the same edge.
- FSM states (encoding in package): IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Command priority when pulses coincide: `clear` > `start` > `pause`. Only the highest-priority pulse acts.
- IDLE
  - Outputs: `num`=START_VAL, step counter 0, `blank`=0, `done`=0.
  - `start` → RUN with step counter 0. `pause` is ignored.
- RUN
  - Step counter increments each cycle.
  - At SEC_DIV-1 the counter wraps to 0, then:
    - if `num`>1: `num` decrements;
    - if `num`==1: `num` becomes 0 and the FSM enters DONE on the same edge.
  - `pause` → PAUSE. `start` is ignored.
- PAUSE
  - Step counter and `num` hold.
  - `start` or `pause` → RUN; counting continues from the held counter value.
- DONE
  - Outputs: `num`=0, `done`=1.
  - Step counter keeps running. `blank` toggles at every SEC_DIV/2 terminal count, giving a 1 s blink period at default settings.
  - `start` → RUN with `num`=START_VAL, counter 0, `blank`=0. `pause` is ignored.
- `clear` in any state → IDLE, reloads `num`, zeroes the step counter, and sets `blank` and `done` to 0. It does not affect the scan.

## Timing
- All outputs are registered. No combinational input-to-output path.
- Reset values: `num`=START_VAL, `row_idx`=0, `row`=8'hFE, `blank`=0, `done`=0, `state`=IDLE, both counters 0.
- `start` sampled at edge E0 → `state`=RUN after E0. First decrement at edge E0+SEC_DIV.
- Full count from START_VAL to 0 takes START_VAL×SEC_DIV cycles after the start edge. `done` rises on the same edge at which `num` reaches 0.
- `row_idx` changes every SCAN_DIV cycles. First change is SCAN_DIV cycles after reset release.
- Counter widths are $clog2 of the respective divider. Counter comparisons use the exact terminal value, so there is no overflow past the terminal count.
- Asynchronous reset mid-RUN returns every output to its reset value immediately. No pulse is remembered across reset.
- A pulse arriving on the same edge as a RUN terminal count:
  - `clear` wins, and no decrement occurs;
  - `pause` takes effect and the decrement still happens on that edge.

## Structure
- Package `dz_pkg`:
  - `dz_state_t` enum (2-bit);
  - `DZ_ROWS`=8;
  - `DZ_NUM_W`=3.
- Sub-module `dz_tick_div`: parameterized terminal-count divider with a `run`/`clr` input and a one-cycle `tick` output. It is instantiated twice: once for scan (always running) and once for step (run = RUN or DONE). The DONE blink uses the step divider with a half-period compare.
- The FSM, `num` register and blank toggle live in the top module.

## Test plan
- Reset, with SCAN_DIV=4: `row` cycles FE, FD, FB … 7F, FE, changing every 4 cycles; `row_idx` wraps 7→0.
- SEC_DIV=10, START_VAL=5, `start` pulse at E0: `num` is 4 at E0+10, 3 at E0+20 … 0 with `done`=1 at E0+50; `blank` toggles every 5 cycles afterwards.
- `pause` at E0+13 and `start` at E0+40: `num` holds at 4 during the pause; the next decrement occurs 7 cycles after resume.
- `clear` and `start` pulsed on the same edge during RUN: FSM goes to IDLE, `num`=5, no further decrements.
- `rst` asserted at E0+25, then `start` after release: all outputs return to reset values; a fresh 50-cycle countdown completes.
- `start` while in DONE: `num`=5, `blank`=0, `done`=0 on the next edge; counting resumes.

Source files
------------

// File: rtl/dz_pkg.sv
// Shared types and sizes for the dot-matrix countdown controller.
package dz_pkg;

  typedef enum logic [1:0] {
    DZ_IDLE  = 2'd0,
    DZ_RUN   = 2'd1,
    DZ_PAUSE = 2'd2,
    DZ_DONE  = 2'd3
  } dz_state_t;

  localparam int DZ_ROWS  = 8;
  localparam int DZ_NUM_W = 3;
  localparam int DZ_ROW_W = $clog2(DZ_ROWS);

endpackage

// File: rtl/dz_tick_div.sv
// Terminal-count divider: counts 0..DIV-1 while i_run is high and flags the
// last count (o_tick) and the half-period count (o_half) combinationally.
module dz_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick,
  output logic o_half
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] HALF = W'(DIV / 2 - 1);

  logic [W-1:0] r_cnt;

  // Clear wins over counting so a coincident command can cancel a wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_run && (r_cnt == LAST);
  assign o_half = i_run && (r_cnt == HALF);

endmodule

// File: rtl/dz_count_ctrl.sv
// Row-scan generator and countdown FSM feeding the 8x8 dot-matrix renderer.
module dz_count_ctrl
  import dz_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int SEC_DIV   = 50_000_000,
  parameter int START_VAL = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  output logic [DZ_NUM_W-1:0] num,
  output logic [DZ_ROW_W-1:0] row_idx,
  output logic [DZ_ROWS-1:0]  row,
  output logic                blank,
  output logic                done,
  output dz_state_t           state
);

  generate
    if (START_VAL < 1 || START_VAL > 7) begin : g_bad_start_val
      $error("dz_count_ctrl: START_VAL must be in 1..7");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("dz_count_ctrl: SCAN_DIV must be at least 2");
    end
    if (SEC_DIV < 2 || (SEC_DIV % 2) != 0) begin : g_bad_sec_div
      $error("dz_count_ctrl: SEC_DIV must be even and at least 2");
    end
  endgenerate

  localparam logic [DZ_NUM_W-1:0] START_NUM = DZ_NUM_W'(START_VAL);
  localparam logic [DZ_ROWS-1:0]  ROW_ONE   = DZ_ROWS'(1);

  logic                w_scan_tick;
  logic                w_scan_half_unused;
  logic [DZ_ROW_W-1:0] w_row_idx_nxt;
  logic [DZ_ROW_W-1:0] r_row_idx;
  logic [DZ_ROWS-1:0]  r_row;

  dz_tick_div #(.DIV(SCAN_DIV)) u_scan_div (
    .clk    (clk),
    .rst    (rst),
    .i_run  (1'b1),
    .i_clr  (1'b0),
    .o_tick (w_scan_tick),
    .o_half (w_scan_half_unused)
  );

  assign w_row_idx_nxt = r_row_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_idx <= '0;
      r_row     <= ~ROW_ONE;
    end else if (w_scan_tick) begin
      r_row_idx <= w_row_idx_nxt;
      r_row     <= ~(ROW_ONE << w_row_idx_nxt);
    end
  end

  dz_state_t           r_state;
  dz_state_t           w_state_nxt;
  logic [DZ_NUM_W-1:0] r_num;
  logic [DZ_NUM_W-1:0] w_num_nxt;
  logic                r_blank;
  logic                w_blank_nxt;
  logic                r_done;
  logic                w_step_run;
  logic                w_step_clr;
  logic                w_step_tick;
  logic                w_step_half;

  assign w_step_run = (r_state == DZ_RUN) || (r_state == DZ_DONE);

  dz_tick_div #(.DIV(SEC_DIV)) u_step_div (
    .clk    (clk),
    .rst    (rst),
    .i_run  (w_step_run),
    .i_clr  (w_step_clr),
    .o_tick (w_step_tick),
    .o_half (w_step_half)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DZ_IDLE;
      r_num   <= START_NUM;
      r_blank <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_num   <= w_num_nxt;
      r_blank <= w_blank_nxt;
      r_done  <= (w_state_nxt == DZ_DONE);
    end
  end

  // Priority clear > start > pause; in RUN a coincident start masks pause.
  always_comb begin
    w_state_nxt = r_state;
    w_num_nxt   = r_num;
    w_blank_nxt = r_blank;
    w_step_clr  = 1'b0;
    if (clear) begin
      w_state_nxt = DZ_IDLE;
      w_num_nxt   = START_NUM;
      w_blank_nxt = 1'b0;
      w_step_clr  = 1'b1;
    end else begin
      case (r_state)
        DZ_IDLE: begin
          if (start) begin
            w_state_nxt = DZ_RUN;
          end
        end
        DZ_RUN: begin
          if (w_step_tick) begin
            w_num_nxt = r_num - 1'b1;
          end
          if (w_step_tick && (r_num <= DZ_NUM_W'(1))) begin
            w_num_nxt   = '0;
            w_state_nxt = DZ_DONE;
          end else if (pause && !start) begin
            w_state_nxt = DZ_PAUSE;
          end
        end
        DZ_PAUSE: begin
          if (start || pause) begin
            w_state_nxt = DZ_RUN;
          end
        end
        DZ_DONE: begin
          if (start) begin
            w_state_nxt = DZ_RUN;
            w_num_nxt   = START_NUM;
            w_blank_nxt = 1'b0;
            w_step_clr  = 1'b1;
          end else if (w_step_tick || w_step_half) begin
            w_blank_nxt = ~r_blank;
          end
        end
        default: begin
          w_state_nxt = DZ_IDLE;
        end
      endcase
    end
  end

  assign num     = r_num;
  assign row_idx = r_row_idx;
  assign row     = r_row;
  assign blank   = r_blank;
  assign done    = r_done;
  assign state   = r_state;

endmodule
